// File: rtl/iter_divider.sv
// Restoring iterative divider for RV32M DIV/DIVU/REM/REMU, one subtract per cycle.
// Latency: WIDTH+1 cycles from accept to out_valid; 1 cycle for divide-by-zero and signed overflow.
// Backpressure: result held in DONE until out_ready; in_ready low whenever not IDLE; kill aborts.
module iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // op encoding: bit0 = unsigned, bit1 = remainder
  localparam logic [1:0] OP_DIV = 2'b00;
  localparam logic [1:0] OP_REM = 2'b10;

  state_t           state;
  state_t           state_nxt;

  logic [1:0]       op_q;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [CW-1:0]    cnt;

  // operand conditioning at accept
  logic             signed_op;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             div_zero;
  logic             sovf;
  logic             special;
  logic [WIDTH-1:0] special_res;
  logic             accept;

  // one iteration of the restoring step
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic             last;

  assign signed_op   = ~op[0];
  assign a_neg       = signed_op & dividend[WIDTH-1];
  assign b_neg       = signed_op & divisor[WIDTH-1];
  assign a_mag       = a_neg ? (~dividend + 1'b1) : dividend;
  assign b_mag       = b_neg ? (~divisor + 1'b1) : divisor;
  assign div_zero    = (divisor == '0);
  assign sovf        = signed_op && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
  assign special     = div_zero | sovf;
  // div-by-zero: quotient all ones, remainder raw dividend; overflow: quotient dividend, remainder 0
  assign special_res = div_zero ? (op[1] ? dividend : '1) : (op[1] ? '0 : dividend);
  assign accept      = (state == IDLE) && in_valid && !kill;

  // An MSB set in the shifted remainder means it already exceeds any divisor,
  // so only the WIDTH+1-bit difference is needed to detect a borrow.
  assign rem_sh  = {rem, quo[WIDTH-1]};
  assign diff    = rem_sh - {1'b0, dvs};
  assign borrow  = ~rem_sh[WIDTH] & diff[WIDTH];
  assign rem_nxt = borrow ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_nxt = {quo[WIDTH-2:0], ~borrow};
  assign last    = (cnt == CW'(WIDTH - 1));
  assign quo_fix = ((sign_a ^ sign_b) && (op_q == OP_DIV)) ? (~quo_nxt + 1'b1) : quo_nxt;
  assign rem_fix = (sign_a && (op_q == OP_REM)) ? (~rem_nxt + 1'b1) : rem_nxt;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state and status outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid && !kill) begin
          state_nxt = special ? DONE : CALC;
        end
      end
      CALC: begin
        if (kill) begin
          state_nxt = IDLE;
        end else if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (kill || out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // operand capture, iteration datapath and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      dvs    <= '0;
      quo    <= '0;
      rem    <= '0;
      cnt    <= '0;
      result <= '0;
    end else if (accept) begin
      op_q   <= op;
      sign_a <= a_neg;
      sign_b <= b_neg;
      dvs    <= b_mag;
      quo    <= a_mag;
      rem    <= '0;
      cnt    <= '0;
      if (special) begin
        result <= special_res;
      end
    end else if ((state == CALC) && !kill) begin
      quo <= quo_nxt;
      rem <= rem_nxt;
      cnt <= cnt + CW'(1);
      if (last) begin
        result <= op_q[1] ? rem_fix : quo_fix;
      end
    end
  end

endmodule
